sort3: RTL and testbench
========================

Name: sort3

Overview:
- Registered three-input sorter for the arithmetic library.
- Each cycle it takes three unsigned WIDTH-bit operands and presents them ordered as maximum, median and minimum.
- Results appear one clock after the inputs are sampled.
- Intended as a building block for median filters and rank-order logic in streaming datapaths.

Parameters:
WIDTH, 8, bit width of every data input and output (unsigned); legal range 1..64.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
data1  input  WIDTH  first operand, unsigned
data2  input  WIDTH  second operand, unsigned
data3  input  WIDTH  third operand, unsigned
max_data  output  WIDTH  largest of the three sampled operands
mid_data  output  WIDTH  median of the three sampled operands
min_data  output  WIDTH  smallest of the three sampled operands

Interface: one clock; reset is asynchronous and active-high. Ports are named clock and reset.

Behaviour:
- Reset:
  - While reset is high, max_data, mid_data and min_data are all 0, regardless of clock.
  - Assertion takes effect immediately, without waiting for a clock edge.
  - Deassertion is sampled on the next rising edge.
- Latency:
  - Exactly 1 cycle.
  - Operands present at rising edge N appear on the outputs after edge N and hold until edge N+1.
  - No valid/ready handshake; a new operand triple is accepted every cycle (throughput 1/cycle).
- Ordering:
  - Unsigned magnitude comparison.
  - Invariant at all times: max_data >= mid_data >= min_data.
  - The output multiset equals the input multiset sampled at the edge.
- Ties:
  - Equal operands are legal.
  - Duplicates appear in the output, e.g. (45,45,40) gives max 45, mid 45, min 40; all equal gives all three outputs equal.
  - Which input index supplies a tied value is unobservable and unconstrained.
- Comparison network: three compare-exchange stages, combinational, followed by one output register bank.
  - Stage A: cmp(data1, data2).
  - Stage B: cmp(hi_A, data3).
  - Stage C: cmp(lo_A, lo_B).
  - max = hi_B, mid = hi_C, min = lo_C.
- Width rules:
  - No widening or truncation; outputs are exact copies of input values.
  - Extremes 0 and 2^WIDTH-1 must sort correctly; no overflow path exists, since there is no subtraction-based compare.
- Reset mid-operation: the in-flight result is discarded and the outputs go to 0. The first post-reset result reflects the operands at the first rising edge with reset low.
- Inputs are assumed stable around the rising edge (synchronous to clock). No internal input registering beyond the single output stage.

Decomposition:
- Shared arithmetic package: nothing block-specific beyond a default data-width constant (DEFAULT_DATA_W = 8), if the package defines one.
- One natural sub-module: sort3_cmp_swap.
  - Parameterised by WIDTH, purely combinational.
  - Inputs a, b; outputs hi = max(a,b), lo = min(a,b); on a == b, hi = a, lo = b.
- sort3 instantiates three sort3_cmp_swap plus the output register bank with asynchronous reset.

Test Plan:
- Reset: drive data (10,5,15), assert reset mid-cycle -> outputs go to 0 immediately and stay 0 across edges while reset is high.
- Mixed order: (10,5,15) sampled at edge -> after that edge max 15, mid 10, min 5.
- Ascending and descending:
  - (20,25,30) -> 30, 25, 20.
  - Next cycle (35,30,25) -> 35, 30, 25.
  - Back-to-back with no bubble, each result one cycle after its inputs.
- Duplicates:
  - (50,50,50) -> 50, 50, 50.
  - (45,45,40) -> 45, 45, 40.
  - (40,45,45) -> 45, 45, 40.
- Extremes: (0,255,128) -> 255, 128, 0; also (255,255,0) -> 255, 255, 0.
- Exhaustive permutation sweep: all 6 orderings of (1,2,3) plus 10k random triples. Scoreboard checks the 1-cycle-delayed sorted result and the invariant max >= mid >= min every cycle; repeat with WIDTH = 1 and 16.

Source files
------------

// File: rtl/sort3_pkg.sv
// Shared constants for the arithmetic library sorter blocks.
package sort3_pkg;

  // Default operand width used when a sorter is instantiated without override.
  localparam int DEFAULT_DATA_W = 8;

endpackage : sort3_pkg

// File: rtl/sort3_cmp_swap.sv
// Combinational compare-exchange element: routes the larger operand to hi
// and the smaller to lo. On a tie, hi takes a and lo takes b; since the
// values are equal the choice is invisible downstream.
module sort3_cmp_swap
  import sort3_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic w_a_ge_b;

  // Plain magnitude compare; no subtraction, so no carry/overflow path exists.
  assign w_a_ge_b = (a >= b);

  // Steer the operands onto the hi/lo outputs.
  always_comb begin
    hi = b;
    lo = a;
    if (w_a_ge_b) begin
      hi = a;
      lo = b;
    end
  end

endmodule : sort3_cmp_swap

// File: rtl/sort3.sv
// Registered three-input unsigned sorter.
// A three-stage compare-exchange network orders the operands combinationally;
// one register bank presents max/mid/min one clock after the inputs are sampled.
// There is no valid/ready handshake: a new triple is accepted on every rising
// edge and its sorted result is visible from just after that edge until the next.
module sort3
  import sort3_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  output logic [WIDTH-1:0] max_data,
  output logic [WIDTH-1:0] mid_data,
  output logic [WIDTH-1:0] min_data
);

  logic [WIDTH-1:0] w_hi_a;
  logic [WIDTH-1:0] w_lo_a;
  logic [WIDTH-1:0] w_hi_b;
  logic [WIDTH-1:0] w_lo_b;
  logic [WIDTH-1:0] w_hi_c;
  logic [WIDTH-1:0] w_lo_c;

  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_mid;
  logic [WIDTH-1:0] r_min;

  // Stage A: order the first two operands.
  sort3_cmp_swap #(.WIDTH(WIDTH)) u_stage_a (
    .a  (data1),
    .b  (data2),
    .hi (w_hi_a),
    .lo (w_lo_a)
  );

  // Stage B: the winner of A against the third operand yields the maximum.
  sort3_cmp_swap #(.WIDTH(WIDTH)) u_stage_b (
    .a  (w_hi_a),
    .b  (data3),
    .hi (w_hi_b),
    .lo (w_lo_b)
  );

  // Stage C: the two remaining losers split into median and minimum.
  sort3_cmp_swap #(.WIDTH(WIDTH)) u_stage_c (
    .a  (w_lo_a),
    .b  (w_lo_b),
    .hi (w_hi_c),
    .lo (w_lo_c)
  );

  // Output register bank; reset clears results immediately and drops any
  // in-flight triple.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_max <= '0;
      r_mid <= '0;
      r_min <= '0;
    end else begin
      r_max <= w_hi_b;
      r_mid <= w_hi_c;
      r_min <= w_lo_c;
    end
  end

  assign max_data = r_max;
  assign mid_data = r_mid;
  assign min_data = r_min;

endmodule : sort3

// File: tb/tb_sort3.sv
// Self-checking bench for sort3: directed vectors with hand-computed results
// on the 8-bit instance, then a random sweep over 1-, 8- and 16-bit instances
// checked against a reference sort and the ordering invariant.
module tb_sort3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT instances ----------------
  logic [7:0]  d8_1 = '0, d8_2 = '0, d8_3 = '0;
  logic [7:0]  max8, mid8, min8;
  logic [0:0]  d1_1 = '0, d1_2 = '0, d1_3 = '0;
  logic [0:0]  max1, mid1, min1;
  logic [15:0] d16_1 = '0, d16_2 = '0, d16_3 = '0;
  logic [15:0] max16, mid16, min16;

  sort3 #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset),
    .data1(d8_1), .data2(d8_2), .data3(d8_3),
    .max_data(max8), .mid_data(mid8), .min_data(min8)
  );

  sort3 #(.WIDTH(1)) u_dut1 (
    .clock(clock), .reset(reset),
    .data1(d1_1), .data2(d1_2), .data3(d1_3),
    .max_data(max1), .mid_data(mid1), .min_data(min1)
  );

  sort3 #(.WIDTH(16)) u_dut16 (
    .clock(clock), .reset(reset),
    .data1(d16_1), .data2(d16_2), .data3(d16_3),
    .max_data(max16), .mid_data(mid16), .min_data(min16)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;

  logic [23:0] exp8_q[$];
  logic [2:0]  exp1_q[$];
  logic [47:0] exp16_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: bubble sort into descending order, returns {max, mid, min}.
  function automatic logic [191:0] sort_ref(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] c);
    logic [63:0] v[3];
    logic [63:0] t;
    v[0] = a; v[1] = b; v[2] = c;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (v[j] < v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
      end
    end
    return {v[0], v[1], v[2]};
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic pop_check8(input string tag);
    logic [23:0] e;
    if (exp8_q.size() == 0) begin
      check({tag, "_qempty"}, 64'd0, 64'd1);
      return;
    end
    e = exp8_q.pop_front();
    check({tag, "_max"}, 64'(max8), 64'(e[23:16]));
    check({tag, "_mid"}, 64'(mid8), 64'(e[15:8]));
    check({tag, "_min"}, 64'(min8), 64'(e[7:0]));
    check({tag, "_inv"}, 64'((max8 >= mid8) && (mid8 >= min8)), 64'd1);
  endtask

  // Drive one 8-bit triple with a hand-computed expectation, check after the edge.
  task automatic vec8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] emax, input logic [7:0] emid,
                      input logic [7:0] emin);
    @(negedge clock);
    d8_1 = a; d8_2 = b; d8_3 = c;
    exp8_q.push_back({emax, emid, emin});
    @(posedge clock);
    #1;
    pop_check8(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_max8"},  64'(max8),  64'd0);
    check({tag, "_mid8"},  64'(mid8),  64'd0);
    check({tag, "_min8"},  64'(min8),  64'd0);
    check({tag, "_any1"},  64'({max1, mid1, min1}), 64'd0);
    check({tag, "_max16"}, 64'(max16), 64'd0);
  endtask

  // One random cycle on all three instances, checked against the reference.
  task automatic rand_cycle();
    logic [63:0] a, b, c;
    logic [191:0] r;
    logic [2:0]  e1;
    logic [47:0] e16;
    @(negedge clock);
    // 8-bit: bias toward ties and extremes
    a = 64'($urandom_range(0, 255));
    b = ($urandom_range(0, 3) == 0) ? a : 64'($urandom_range(0, 255));
    c = ($urandom_range(0, 7) == 0) ? 64'(($urandom_range(0, 1) == 1) ? 255 : 0)
                                    : 64'($urandom_range(0, 255));
    d8_1 = a[7:0]; d8_2 = b[7:0]; d8_3 = c[7:0];
    r = sort_ref(a, b, c);
    exp8_q.push_back({r[135:128], r[71:64], r[7:0]});
    // 1-bit
    a = 64'($urandom_range(0, 1)); b = 64'($urandom_range(0, 1)); c = 64'($urandom_range(0, 1));
    d1_1 = a[0:0]; d1_2 = b[0:0]; d1_3 = c[0:0];
    r = sort_ref(a, b, c);
    exp1_q.push_back({r[128], r[64], r[0]});
    // 16-bit
    a = 64'($urandom_range(0, 65535));
    b = ($urandom_range(0, 3) == 0) ? a : 64'($urandom_range(0, 65535));
    c = ($urandom_range(0, 7) == 0) ? 64'(($urandom_range(0, 1) == 1) ? 65535 : 0)
                                    : 64'($urandom_range(0, 65535));
    d16_1 = a[15:0]; d16_2 = b[15:0]; d16_3 = c[15:0];
    r = sort_ref(a, b, c);
    exp16_q.push_back({r[143:128], r[79:64], r[15:0]});
    @(posedge clock);
    #1;
    pop_check8("rnd8");
    e1 = exp1_q.pop_front();
    check("rnd1_max", 64'(max1), 64'(e1[2]));
    check("rnd1_mid", 64'(mid1), 64'(e1[1]));
    check("rnd1_min", 64'(min1), 64'(e1[0]));
    check("rnd1_inv", 64'((max1 >= mid1) && (mid1 >= min1)), 64'd1);
    e16 = exp16_q.pop_front();
    check("rnd16_max", 64'(max16), 64'(e16[47:32]));
    check("rnd16_mid", 64'(mid16), 64'(e16[31:16]));
    check("rnd16_min", 64'(min16), 64'(e16[15:0]));
    check("rnd16_inv", 64'((max16 >= mid16) && (mid16 >= min16)), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state, held across edges
    #1;
    check_all_zero("rst_init");
    @(posedge clock); #1;
    @(posedge clock); #1;
    check_all_zero("rst_hold");
    @(negedge clock);
    reset = 1'b0;

    // Mixed order, first result after reset release
    vec8("mixed", 8'd10, 8'd5, 8'd15, 8'd15, 8'd10, 8'd5);

    // Asynchronous reset mid-cycle with operands still applied
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(posedge clock); #1;
    check_all_zero("rst_edge1");
    @(posedge clock); #1;
    check_all_zero("rst_edge2");
    @(negedge clock);
    reset = 1'b0;

    // Back-to-back directed vectors
    vec8("asc",     8'd20,  8'd25,  8'd30,  8'd30,  8'd25,  8'd20);
    vec8("desc",    8'd35,  8'd30,  8'd25,  8'd35,  8'd30,  8'd25);
    vec8("mixed2",  8'd10,  8'd5,   8'd15,  8'd15,  8'd10,  8'd5);
    vec8("dup_all", 8'd50,  8'd50,  8'd50,  8'd50,  8'd50,  8'd50);
    vec8("dup_hi",  8'd45,  8'd45,  8'd40,  8'd45,  8'd45,  8'd40);
    vec8("dup_hi2", 8'd40,  8'd45,  8'd45,  8'd45,  8'd45,  8'd40);
    vec8("dup_lo",  8'd7,   8'd3,   8'd3,   8'd7,   8'd3,   8'd3);
    vec8("ext",     8'd0,   8'd255, 8'd128, 8'd255, 8'd128, 8'd0);
    vec8("ext2",    8'd255, 8'd255, 8'd0,   8'd255, 8'd255, 8'd0);
    vec8("zeros",   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0);

    // All six orderings of (1,2,3)
    vec8("perm123", 8'd1, 8'd2, 8'd3, 8'd3, 8'd2, 8'd1);
    vec8("perm132", 8'd1, 8'd3, 8'd2, 8'd3, 8'd2, 8'd1);
    vec8("perm213", 8'd2, 8'd1, 8'd3, 8'd3, 8'd2, 8'd1);
    vec8("perm231", 8'd2, 8'd3, 8'd1, 8'd3, 8'd2, 8'd1);
    vec8("perm312", 8'd3, 8'd1, 8'd2, 8'd3, 8'd2, 8'd1);
    vec8("perm321", 8'd3, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1);

    // Random sweep across widths 1, 8 and 16
    for (int i = 0; i < 10000; i++) begin
      rand_cycle();
    end

    // Reset after the sweep clears every instance again
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_all_zero("rst_final");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_sort3
